// File: rtl/slow_clock_monitor.sv
// Slow clock monitor: synchronises slowIn into clkIn, emits edge ticks, measures period and tracks lock/loss.
// Optional high-time measurement is built when SLOW_CLOCK_MON_DUTY_EN is defined.
module slow_clock_monitor #(
   parameter int CNT_W      = 16,
   parameter int EXP_PERIOD = 22,
   parameter int TOL        = 2,
   parameter int LOCK_COUNT = 4,
   parameter int TIMEOUT    = 64
) (
   input  logic             clkIn,
   input  logic             rst,
   input  logic             slowIn,
   output logic             riseTick,
   output logic             fallTick,
   output logic [CNT_W-1:0] period,
   output logic             periodValid,
   output logic             locked,
   output logic             lost,
   output logic [1:0]       state,
   output logic [CNT_W-1:0] highTime,
   output logic             highValid
);
   typedef enum logic [1:0] {IDLE = 2'd0, ACQ = 2'd1, LOCKED = 2'd2, LOST = 2'd3} state_t;

   localparam int IDLE_W = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0]  PER_MIN   = CNT_W'(EXP_PERIOD - TOL);
   localparam logic [CNT_W-1:0]  PER_MAX   = CNT_W'(EXP_PERIOD + TOL);
   localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);
   localparam logic [IDLE_W-1:0] IDLE_SAT  = IDLE_W'(TIMEOUT);
   localparam logic [3:0]        LOCK_N    = 4'(LOCK_COUNT);

   function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
      satInc = (v == CNT_MAX) ? CNT_MAX : v + CNT_W'(1);
   endfunction

   logic              s1, s2, s3;
   logic              rise, fall, timeout, perUpd, perGood, seenRise, dropSeen;
   logic [CNT_W-1:0]  cnt, perNext;
   logic [IDLE_W-1:0] idleCnt;
   logic [3:0]        goodCnt, nextGood;
   state_t            curState, nextState;

   assign rise    = s2 & ~s3;
   assign fall    = ~s2 & s3;
   assign perUpd  = rise & seenRise;
   assign perNext = satInc(cnt);
   assign perGood = (perNext >= PER_MIN) && (perNext <= PER_MAX) && (perNext != CNT_MAX);
   // An edge in the deciding cycle always beats the timeout.
   assign timeout = ~(rise | fall) & (idleCnt >= IDLE_LAST);
   assign state   = curState;

   // Next-state and lock-count logic
   always_comb begin
      nextState = curState;
      nextGood  = goodCnt;
      dropSeen  = 1'b0;
      case (curState)
         IDLE: begin
            if (rise) begin
               nextState = ACQ;
               nextGood  = 4'd0;
            end else if (timeout) begin
               nextState = LOST;
               dropSeen  = 1'b1;
            end else begin
               nextState = IDLE;
            end
         end
         ACQ: begin
            if (perUpd) begin
               if (perGood) begin
                  nextGood  = goodCnt + 4'd1;
                  nextState = ((goodCnt + 4'd1) >= LOCK_N) ? LOCKED : ACQ;
               end else begin
                  nextGood  = 4'd0;
               end
            end else if (timeout) begin
               nextState = LOST;
               dropSeen  = 1'b1;
            end else begin
               nextState = ACQ;
            end
         end
         LOCKED: begin
            if (perUpd && !perGood) begin
               nextState = ACQ;
               nextGood  = 4'd0;
            end else if (timeout) begin
               nextState = LOST;
               dropSeen  = 1'b1;
            end else begin
               nextState = LOCKED;
            end
         end
         LOST: begin
            if (rise) begin
               nextState = ACQ;
               nextGood  = 4'd0;
            end else begin
               nextState = LOST;
            end
         end
         default: begin
            nextState = IDLE;
            nextGood  = 4'd0;
         end
      endcase
   end

   // Synchroniser, edge ticks, period/idle counters and registered FSM outputs
   always_ff @(posedge clkIn) begin
      if (rst) begin
         s1          <= 1'b0;
         s2          <= 1'b0;
         s3          <= 1'b0;
         riseTick    <= 1'b0;
         fallTick    <= 1'b0;
         cnt         <= {CNT_W{1'b0}};
         period      <= {CNT_W{1'b0}};
         periodValid <= 1'b0;
         idleCnt     <= {IDLE_W{1'b0}};
         seenRise    <= 1'b0;
         goodCnt     <= 4'd0;
         curState    <= IDLE;
         locked      <= 1'b0;
         lost        <= 1'b0;
      end else begin
         s1          <= slowIn;
         s2          <= s1;
         s3          <= s2;
         riseTick    <= rise;
         fallTick    <= fall;
         cnt         <= rise ? {CNT_W{1'b0}} : satInc(cnt);
         periodValid <= perUpd;
         if (perUpd) begin
            period <= perNext;
         end
         if (rise | fall) begin
            idleCnt <= {IDLE_W{1'b0}};
         end else if (idleCnt != IDLE_SAT) begin
            idleCnt <= idleCnt + IDLE_W'(1);
         end
         // Losing the clock forgets the previous rise so the next one only restarts measurement.
         if (dropSeen) begin
            seenRise <= 1'b0;
         end else if (rise) begin
            seenRise <= 1'b1;
         end
         goodCnt     <= nextGood;
         curState    <= nextState;
         locked      <= (nextState == LOCKED);
         lost        <= (nextState == LOST);
      end
   end

`ifdef SLOW_CLOCK_MON_DUTY_EN
   logic [CNT_W-1:0] highCnt;

   // High-time counter, captured on each fall that follows a seen rise
   always_ff @(posedge clkIn) begin
      if (rst) begin
         highCnt   <= {CNT_W{1'b0}};
         highTime  <= {CNT_W{1'b0}};
         highValid <= 1'b0;
      end else begin
         if (rise) begin
            highCnt <= {CNT_W{1'b0}};
         end else if (s2) begin
            highCnt <= satInc(highCnt);
         end
         highValid <= fall & seenRise;
         if (fall & seenRise) begin
            highTime <= satInc(highCnt);
         end
      end
   end
`else
   assign highTime  = {CNT_W{1'b0}};
   assign highValid = 1'b0;
`endif

endmodule

// File: tb/tb_slow_clock_monitor.sv
// Testbench for slow_clock_monitor: directed and randomized slow waves checked every cycle
// against an edge-index model of ticks, periods, lock and loss.
module tb_slow_clock_monitor;
   localparam int CNT_W = 16;
   localparam int EXP_PERIOD = 22;
   localparam int TOL = 2;
   localparam int LOCK_COUNT = 4;
   localparam int TIMEOUT = 64;
   localparam int MAXV = (1 << CNT_W) - 1;

   logic             clkIn = 1'b0;
   logic             rst = 1'b1;
   logic             slowIn = 1'b0;
   logic             riseTick, fallTick, periodValid, locked, lost, highValid;
   logic [CNT_W-1:0] period, highTime;
   logic [1:0]       state;

   int checks = 0;
   int failures = 0;

   slow_clock_monitor #(
      .CNT_W(CNT_W), .EXP_PERIOD(EXP_PERIOD), .TOL(TOL),
      .LOCK_COUNT(LOCK_COUNT), .TIMEOUT(TIMEOUT)
   ) dut (
      .clkIn(clkIn), .rst(rst), .slowIn(slowIn),
      .riseTick(riseTick), .fallTick(fallTick),
      .period(period), .periodValid(periodValid),
      .locked(locked), .lost(lost), .state(state),
      .highTime(highTime), .highValid(highValid)
   );

   always #5 clkIn = ~clkIn;

   // Model: edge indices since reset; a sample taken at edge j shows as a tick at edge j+2.
   bit hist [0:19999];
   int k, lastRise, lastEdge, mState, mGood, mPeriod, mHigh;
   bit haveRise, eRise, eFall, ePV, eHV;

   function automatic bit h(input int j);
      return (j < 1) ? 1'b0 : hist[j];
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d (edge %0d)", tag, obs, expv, k);
      end
   endtask

   task automatic modelEdge(input bit v, input bit r);
      bit tmo, good;
      int diff;
      if (r) begin
         k = 0; hist[0] = 1'b0; lastRise = 0; lastEdge = 0;
         mState = 0; mGood = 0; mPeriod = 0; mHigh = 0;
         haveRise = 1'b0; eRise = 1'b0; eFall = 1'b0; ePV = 1'b0; eHV = 1'b0;
      end else begin
         k++;
         hist[k] = v;
         eRise = h(k - 2) && !h(k - 3);
         eFall = !h(k - 2) && h(k - 3);
         ePV = 1'b0;
         eHV = 1'b0;
         good = 1'b0;
         tmo = !(eRise || eFall) && ((k - lastEdge) >= TIMEOUT);
         if (eRise || eFall) lastEdge = k;
         diff = k - lastRise;
         if (diff > MAXV) diff = MAXV;
`ifdef SLOW_CLOCK_MON_DUTY_EN
         if (eFall && haveRise) begin
            eHV = 1'b1;
            mHigh = diff;
         end
`endif
         if (eRise && haveRise) begin
            ePV = 1'b1;
            mPeriod = diff;
            good = (diff >= EXP_PERIOD - TOL) && (diff <= EXP_PERIOD + TOL) && (diff != MAXV);
         end
         case (mState)
            0: if (eRise) begin mState = 1; mGood = 0; end
               else if (tmo) begin mState = 3; haveRise = 1'b0; end
            1: if (ePV) begin
                  if (good) begin
                     mGood++;
                     if (mGood >= LOCK_COUNT) mState = 2;
                  end else mGood = 0;
               end else if (tmo) begin mState = 3; haveRise = 1'b0; end
            2: if (ePV && !good) begin mState = 1; mGood = 0; end
               else if (tmo) begin mState = 3; haveRise = 1'b0; end
            default: if (eRise) begin mState = 1; mGood = 0; end
         endcase
         if (eRise) begin
            haveRise = 1'b1;
            lastRise = k;
         end
      end
   endtask

   task automatic checkAll();
      chk("riseTick", riseTick, eRise);
      chk("fallTick", fallTick, eFall);
      chk("periodValid", periodValid, ePV);
      chk("period", period, mPeriod);
      chk("state", state, mState);
      chk("locked", locked, mState == 2);
      chk("lost", lost, mState == 3);
      chk("highValid", highValid, eHV);
      chk("highTime", highTime, mHigh);
   endtask

   task automatic step(input bit v);
      slowIn = v;
      @(posedge clkIn);
      #1;
      modelEdge(v, rst);
      checkAll();
   endtask

   task automatic wave(input int hi, input int lo, input int n);
      for (int i = 0; i < n; i++) begin
         repeat (hi) step(1'b1);
         repeat (lo) step(1'b0);
      end
   endtask

   initial begin
      int p, hi;
      // reset state
      rst = 1'b1;
      repeat (3) step(1'b0);
      chk("reset_state", state, 2'd0);
      chk("reset_period", period, 16'd0);
      rst = 1'b0;

      // 11/11 wave locks on the 5th rise
      wave(11, 11, 6);
      chk("lock_state", state, 2'd2);
      chk("lock_flag", locked, 1'b1);

      // one 30-cycle period drops lock, four good periods relock
      wave(15, 15, 1);
      wave(11, 11, 5);
      chk("relock_state", state, 2'd2);

      // tolerance edges: 20 and 24 good, 25 bad
      wave(10, 10, 1);
      wave(12, 12, 1);
      wave(11, 11, 1);
      chk("tol_20_24_state", state, 2'd2);
      wave(12, 13, 1);
      wave(11, 11, 1);
      chk("tol_25_state", state, 2'd1);
      wave(11, 11, 4);
      chk("tol_relock_state", state, 2'd2);
      wave(9, 10, 1);
      wave(11, 11, 1);
      chk("tol_19_state", state, 2'd1);
      wave(11, 11, 4);

      // loss of clock after 64 idle cycles, then reacquire
      repeat (100) step(1'b0);
      chk("lost_state", state, 2'd3);
      chk("lost_flag", lost, 1'b1);
      wave(11, 11, 6);
      chk("after_lost_lock", state, 2'd2);

      // edge exactly at the timeout boundary wins; one cycle later it does not
      repeat (64) step(1'b1);
      repeat (3) step(1'b0);
      chk("boundary_no_lost", lost, 1'b0);
      repeat (67) step(1'b0);
      chk("boundary_lost", lost, 1'b1);
      wave(11, 11, 6);

      // rst in mid-period
      repeat (5) step(1'b1);
      rst = 1'b1;
      step(1'b1);
      rst = 1'b0;
      chk("midrst_state", state, 2'd0);
      chk("midrst_locked", locked, 1'b0);
      repeat (6) step(1'b1);
      wave(11, 11, 6);

      // duty-cycle wave 7/15
      wave(7, 15, 6);
      chk("duty_lock_state", state, 2'd2);

      // randomized periods, duty and occasional long gaps
      for (int it = 0; it < 60; it++) begin
         p = $urandom_range(27, 17);
         hi = $urandom_range(p - 4, 4);
         wave(hi, p - hi, 1);
         if ($urandom_range(9, 0) == 0) repeat ($urandom_range(80, 50)) step(1'b0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
